hack_data_port: RTL and testbench

- Responder for the Hack CPU data-memory interface: the CPU drives addressM, outM and loadM, and this block returns inM.
- Contains the data RAM plus a small memory-mapped I/O page:
  - keyboard latch
  - console TX FIFO with a valid/ready output stream
  - free-running timer
  - LED register
- Sits beside the CPU at top level; the instruction ROM is separate.

---
 rtl/hack_data_port.sv | 125 ++++++++++++
 tb/tb_hack_data_port.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/hack_data_port.sv
// rtl/hack_data_port.sv - Hack CPU data-memory responder: RAM plus keyboard, console FIFO, timer and LED page
module hack_data_port #(
  parameter int RAM_AW     = 10,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] addressM,
  input  logic [15:0] outM,
  input  logic        loadM,
  output logic [15:0] inM,
  input  logic [15:0] key,
  output logic [15:0] con_data,
  output logic        con_valid,
  input  logic        con_ready,
  output logic [15:0] led
);

  localparam int          PW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [4:0]  DEPTH5   = 5'(FIFO_DEPTH);
  localparam logic [15:0] A_KBD    = 16'h6000;
  localparam logic [15:0] A_CDATA  = 16'h6001;
  localparam logic [15:0] A_CSTAT  = 16'h6002;
  localparam logic [15:0] A_TIMER  = 16'h6003;
  localparam logic [15:0] A_LED    = 16'h6004;

  // Storage without reset: RAM and FIFO payload
  logic [15:0] ram_q  [2**RAM_AW];
  logic [15:0] fifo_q [FIFO_DEPTH];

  // Registered state and next-state
  logic [15:0] kbd_q, timer_q, timer_d, led_q, led_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [4:0]  count_q, count_d;
  logic        ovf_q, ovf_d;

  // Decode and handshake
  logic              ram_hit;
  logic [RAM_AW-1:0] ram_addr;
  logic              fifo_empty, fifo_full, push, push_ok, pop;
  logic [15:0]       stat;

  assign ram_hit    = (addressM >> RAM_AW) == 16'd0;
  assign ram_addr   = addressM[RAM_AW-1:0];
  assign fifo_empty = (count_q == 5'd0);
  assign fifo_full  = (count_q == DEPTH5);
  assign con_valid  = !fifo_empty;
  assign con_data   = fifo_empty ? 16'h0000 : fifo_q[rd_ptr_q];
  assign pop        = con_valid && con_ready;
  assign push       = loadM && (addressM == A_CDATA);
  // A full FIFO still accepts when the head leaves in the same cycle
  assign push_ok    = push && (!fifo_full || pop);
  assign stat       = {7'd0, count_q, 1'b0, ovf_q, fifo_empty, fifo_full};
  assign led        = led_q;

  // RAM write port; a write overlapping reset is discarded
  always_ff @(posedge clk) begin
    if (!reset && loadM && ram_hit) ram_q[ram_addr] <= outM;
  end

  // FIFO payload write at the tail
  always_ff @(posedge clk) begin
    if (!reset && push_ok) fifo_q[wr_ptr_q] <= outM;
  end

  // Next-state for pointers, count, overflow, timer and LED
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    led_d    = led_q;
    timer_d  = timer_q + 16'd1;
    if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)     rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push_ok, pop})
      2'b10:   count_d = count_q + 5'd1;
      2'b01:   count_d = count_q - 5'd1;
      default: count_d = count_q;
    endcase
    if (loadM && addressM == A_CSTAT) ovf_d = 1'b0;
    // Dropped push sets overflow after the clear so a same-cycle set wins
    if (push && fifo_full && !pop) ovf_d = 1'b1;
    if (loadM && addressM == A_TIMER) timer_d = outM;
    if (loadM && addressM == A_LED)   led_d   = outM;
  end

  // State registers with asynchronous reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      kbd_q    <= 16'h0000;
      timer_q  <= 16'h0000;
      led_q    <= 16'h0000;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= 5'd0;
      ovf_q    <= 1'b0;
    end else begin
      kbd_q    <= key;
      timer_q  <= timer_d;
      led_q    <= led_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // Zero-latency read mux; unmapped addresses read 0
  always_comb begin
    inM = 16'h0000;
    if (ram_hit) begin
      inM = ram_q[ram_addr];
    end else begin
      case (addressM)
        A_KBD:   inM = kbd_q;
        A_CSTAT: inM = stat;
        A_TIMER: inM = timer_q;
        A_LED:   inM = led_q;
        default: inM = 16'h0000;
      endcase
    end
  end

endmodule

// File: tb/tb_hack_data_port.sv
// tb/tb_hack_data_port.sv - directed self-checking bench for hack_data_port
module tb_hack_data_port;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] addressM, outM, key;
  logic        loadM, con_ready;
  logic [15:0] inM, con_data, led;
  logic        con_valid;

  int n_cmp = 0;
  int n_err = 0;

  hack_data_port #(.RAM_AW(10), .FIFO_DEPTH(8)) dut (
    .clk(clk), .reset(reset), .addressM(addressM), .outM(outM), .loadM(loadM),
    .inM(inM), .key(key), .con_data(con_data), .con_valid(con_valid),
    .con_ready(con_ready), .led(led)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    addressM = a;
    outM     = d;
    loadM    = 1'b1;
    step();
    loadM    = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [15:0] a, input logic [15:0] exp);
    addressM = a;
    #1;
    check(tag, inM, exp);
  endtask

  initial begin
    reset = 1'b1; addressM = 16'h0; outM = 16'h0; loadM = 1'b0;
    key = 16'h0; con_ready = 1'b0;
    step();
    step();
    reset = 1'b0;

    // Reset state
    check("rst_valid", {15'd0, con_valid}, 16'h0);
    check("rst_data", con_data, 16'h0);
    check("rst_led", led, 16'h0);
    rd("rst_stat", 16'h6002, 16'h0002);
    rd("rst_kbd", 16'h6000, 16'h0000);
    rd("rst_timer", 16'h6003, 16'h0000);

    // Timer counts cycles from release, then load and wrap
    repeat (5) step();
    rd("timer_n5", 16'h6003, 16'd5);
    wr(16'h6003, 16'hFFFE);
    rd("timer_load", 16'h6003, 16'hFFFE);
    step();
    rd("timer_ffff", 16'h6003, 16'hFFFF);
    step();
    rd("timer_wrap", 16'h6003, 16'h0000);

    // RAM
    wr(16'h0005, 16'h1234);
    rd("ram5", 16'h0005, 16'h1234);
    wr(16'h0000, 16'hBEEF);
    wr(16'h0400, 16'h5555);
    rd("ram_oor", 16'h0400, 16'h0000);
    rd("ram0_kept", 16'h0000, 16'hBEEF);
    rd("unmapped", 16'h7000, 16'h0000);

    // Keyboard latch has one cycle of latency
    key = 16'h0020;
    rd("kbd_before", 16'h6000, 16'h0000);
    step();
    rd("kbd_after", 16'h6000, 16'h0020);
    key = 16'h0000;

    // LED: same-cycle read sees the old value
    addressM = 16'h6004; outM = 16'hA5A5; loadM = 1'b1;
    #1;
    check("led_old", inM, 16'h0000);
    step();
    loadM = 1'b0;
    check("led_out", led, 16'hA5A5);
    rd("led_rd", 16'h6004, 16'hA5A5);

    // FIFO order and handshake
    con_ready = 1'b0;
    addressM = 16'h6001; outM = 16'h0041; loadM = 1'b1;
    #1;
    check("fwft_pre", {15'd0, con_valid}, 16'h0);
    step();
    loadM = 1'b0;
    check("fwft_post", {15'd0, con_valid}, 16'h1);
    wr(16'h6001, 16'h0042);
    wr(16'h6001, 16'h0043);
    rd("stat3", 16'h6002, 16'h0030);
    rd("cdata_rd0", 16'h6001, 16'h0000);
    check("head41", con_data, 16'h0041);
    con_ready = 1'b1;
    step();
    check("head42", con_data, 16'h0042);
    step();
    check("head43", con_data, 16'h0043);
    step();
    con_ready = 1'b0;
    check("drained_valid", {15'd0, con_valid}, 16'h0);
    check("drained_data", con_data, 16'h0);
    rd("drained_stat", 16'h6002, 16'h0002);

    // Overflow: nine pushes into depth 8
    for (int i = 0; i < 9; i++) wr(16'h6001, 16'h0100 + 16'(i));
    rd("ovf_stat", 16'h6002, 16'h0085);
    wr(16'h6002, 16'h0000);
    rd("ovf_clr", 16'h6002, 16'h0081);
    addressM = 16'h6001; outM = 16'h0200; loadM = 1'b1; con_ready = 1'b1;
    step();
    loadM = 1'b0; con_ready = 1'b0;
    rd("full_pushpop", 16'h6002, 16'h0081);
    con_ready = 1'b1;
    for (int i = 1; i < 8; i++) begin
      check("ovf_drain", con_data, 16'h0100 + 16'(i));
      step();
    end
    check("ovf_last", con_data, 16'h0200);
    step();
    con_ready = 1'b0;
    check("ovf_empty", {15'd0, con_valid}, 16'h0);
    rd("ovf_stat_end", 16'h6002, 16'h0002);

    // Mid-operation asynchronous reset
    wr(16'h6001, 16'h0011);
    wr(16'h6001, 16'h0022);
    wr(16'h6001, 16'h0033);
    wr(16'h6004, 16'h00FF);
    wr(16'h6003, 16'h0100);
    rd("pre_timer", 16'h6003, 16'h0100);
    check("pre_valid", {15'd0, con_valid}, 16'h1);
    #2;
    reset = 1'b1;
    #1;
    check("arst_valid", {15'd0, con_valid}, 16'h0);
    check("arst_led", led, 16'h0);
    check("arst_data", con_data, 16'h0);
    addressM = 16'h6004; outM = 16'h1111; loadM = 1'b1;
    step();
    loadM = 1'b0;
    reset = 1'b0;
    check("post_led", led, 16'h0);
    rd("post_stat", 16'h6002, 16'h0002);
    rd("post_timer0", 16'h6003, 16'h0000);
    repeat (3) step();
    rd("post_timer3", 16'h6003, 16'd3);
    rd("ram5_kept", 16'h0005, 16'h1234);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
